// File: rtl/nco_pkg.sv
// Shared widths, LFSR constants and the dither alignment helper for the NCO.
package nco_pkg;

    localparam int NBF_DEF = 48;
    localparam int NBA_DEF = 22;
    localparam int NBC_DEF = 24;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shift form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Left shift that places the LFSR MSB one bit below the truncation point.
    // A negative result means the LFSR is wider than the discarded field and
    // must be shifted right instead.
    function automatic int dither_lshift(input int nbf, input int nba);
        return nbf - nba - LFSR_W;
    endfunction

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Galois LFSR used as the truncation dither source.
module nco_lfsr
    import nco_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // advance one step per clock; reset reloads the nonzero seed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LFSR_SEED;
        end else begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/nco_phase_acc.sv
// Phase accumulator NCO with offset, sync clear, linear chirp and optional
// LFSR truncation dither. Produces one angle word per clock for sincos.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int NBF    = NBF_DEF,
    parameter int NBA    = NBA_DEF,
    parameter int DITHER = 1,
    parameter int NBC    = NBC_DEF
) (
    input  logic           c,
    input  logic           r,
    input  logic           freq_wr,
    input  logic [NBF-1:0] freq,
    input  logic           poff_wr,
    input  logic [NBA-1:0] poff,
    input  logic           sync,
    input  logic           sweep_start,
    input  logic [NBF-1:0] sweep_step,
    input  logic [NBC-1:0] sweep_len,
    output logic           sweep_busy,
    output logic [NBF-1:0] freq_cur,
    output logic [NBA-1:0] a
);

    logic [NBF-1:0] r_f;
    logic [NBF-1:0] r_step;
    logic [NBC-1:0] r_cnt;
    logic           r_busy;
    logic [NBF-1:0] r_acc;
    logic [NBA-1:0] r_poff;
    logic [NBA-1:0] r_a;
    logic [NBF-1:0] w_dither;

    generate
        if (DITHER != 0) begin : g_dither
            localparam int DSH = dither_lshift(NBF, NBA);
            logic [15:0] w_lfsr;

            nco_lfsr u_lfsr (
                .i_clk   (c),
                .i_rst   (r),
                .o_state (w_lfsr)
            );

            if (DSH >= 0) begin : g_up
                assign w_dither = NBF'(w_lfsr) << DSH;
            end else begin : g_dn
                assign w_dither = NBF'(w_lfsr >> (-DSH));
            end
        end else begin : g_plain
            assign w_dither = '0;
        end
    endgenerate

    // frequency register and chirp engine; a direct write always beats a sweep
    always_ff @(posedge c) begin
        if (r) begin
            r_f    <= '0;
            r_step <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (freq_wr) begin
            r_f    <= freq;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (sweep_start) begin
            // restart takes effect without applying an increment this cycle
            r_step <= sweep_step;
            r_cnt  <= sweep_len;
            r_busy <= (sweep_len != '0);
        end else if (r_busy) begin
            r_f   <= r_f + r_step;
            r_cnt <= r_cnt - NBC'(1);
            if (r_cnt == NBC'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // accumulate with pre-update frequency, then dither, truncate and offset
    always_ff @(posedge c) begin
        if (r) begin
            r_acc  <= '0;
            r_poff <= '0;
            r_a    <= '0;
        end else begin
            r_acc <= sync ? '0 : r_acc + r_f;
            if (poff_wr) begin
                r_poff <= poff;
            end
            // dither sum wraps at NBF before the top NBA bits are kept
            r_a <= NBA'((r_acc + w_dither) >> (NBF - NBA)) + r_poff;
        end
    end

    assign sweep_busy = r_busy;
    assign freq_cur   = r_f;
    assign a          = r_a;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed bench for nco_phase_acc: an undithered instance checks exact
// angles and sweep behaviour, a dithered instance checks dither statistics.
module tb_nco_phase_acc;

    logic c = 1'b0;
    always #5 c = ~c;

    logic        r, freq_wr, poff_wr, sync, sweep_start;
    logic [47:0] freq, sweep_step;
    logic [21:0] poff;
    logic [23:0] sweep_len;

    logic        busy0, busy1;
    logic [47:0] fc0, fc1;
    logic [21:0] a0, a1;

    int vectors     = 0;
    int miscompares = 0;

    nco_phase_acc #(.NBF(48), .NBA(22), .DITHER(0), .NBC(24)) dut0 (
        .c(c), .r(r), .freq_wr(freq_wr), .freq(freq), .poff_wr(poff_wr), .poff(poff),
        .sync(sync), .sweep_start(sweep_start), .sweep_step(sweep_step),
        .sweep_len(sweep_len), .sweep_busy(busy0), .freq_cur(fc0), .a(a0)
    );

    nco_phase_acc #(.NBF(48), .NBA(22), .DITHER(1), .NBC(24)) dut1 (
        .c(c), .r(r), .freq_wr(freq_wr), .freq(freq), .poff_wr(poff_wr), .poff(poff),
        .sync(sync), .sweep_start(sweep_start), .sweep_step(sweep_step),
        .sweep_len(sweep_len), .sweep_busy(busy1), .freq_cur(fc1), .a(a1)
    );

    task automatic step();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    localparam logic [47:0] F_DITH = (48'd1 << 25) + 48'd1;

    logic [47:0] ideal;
    logic [47:0] e;
    logic [21:0] aprev, dd;
    longint      sum, err, tol;
    int          bad0, bad1, dcnt, nbusy;

    initial begin
        r = 1'b1; freq_wr = 1'b0; freq = '0; poff_wr = 1'b0; poff = '0;
        sync = 1'b0; sweep_start = 1'b0; sweep_step = '0; sweep_len = '0;
        step(); step();
        chk("rst_a", 64'(a0), 64'h0);
        chk("rst_freq_cur", 64'(fc0), 64'h0);
        chk("rst_busy", 64'(busy0), 64'h0);

        // basic ramp: one output LSB per clock, two clocks of latency
        r = 1'b0; freq_wr = 1'b1; freq = 48'd1 << 26;
        step(); freq_wr = 1'b0;
        chk("ramp_freq_cur", 64'(fc0), 64'h400_0000);
        chk("ramp_a_edge0", 64'(a0), 64'h0);
        step();
        chk("ramp_a_edge1", 64'(a0), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ramp_inc", 64'(a0), 64'(k));
        end

        // offset pushes the ramp up to the wrap point
        poff_wr = 1'b1; poff = 22'h3FFFF8;
        step(); poff_wr = 1'b0;
        chk("poff_latency", 64'(a0), 64'h5);
        step(); chk("wrap_3ffffe", 64'(a0), 64'h3FFFFE);
        step(); chk("wrap_3fffff", 64'(a0), 64'h3FFFFF);
        step(); chk("wrap_0", 64'(a0), 64'h0);
        step(); chk("wrap_1", 64'(a0), 64'h1);

        // sync + freq_wr together, zero frequency, then the offset alone
        freq_wr = 1'b1; freq = '0; sync = 1'b1; poff_wr = 1'b1; poff = '0;
        step(); freq_wr = 1'b0; sync = 1'b0; poff_wr = 1'b0;
        step(); chk("poff_zero", 64'(a0), 64'h0);
        poff_wr = 1'b1; poff = 22'h100000;
        step(); poff_wr = 1'b0;
        chk("poff_old", 64'(a0), 64'h0);
        step(); chk("poff_new", 64'(a0), 64'h100000);
        sync = 1'b1;
        step(); sync = 1'b0;
        chk("sync_hold0", 64'(a0), 64'h100000);
        step(); chk("sync_hold1", 64'(a0), 64'h100000);

        // write latency and sync with a running phase
        freq_wr = 1'b1; freq = 48'd3 << 26;
        step(); freq_wr = 1'b0;
        chk("fw_a_edge0", 64'(a0), 64'h100000);
        step(); chk("fw_a_edge1", 64'(a0), 64'h100000);
        step(); chk("fw_a_edge2", 64'(a0), 64'h100003);
        sync = 1'b1;
        step(); sync = 1'b0;
        chk("sync_edge0", 64'(a0), 64'h100006);
        step(); chk("sync_edge1", 64'(a0), 64'h100000);
        step(); chk("sync_edge2", 64'(a0), 64'h100003);

        // sweep of five increments from zero
        freq_wr = 1'b1; freq = '0;
        step(); freq_wr = 1'b0;
        sweep_start = 1'b1; sweep_step = 48'd1 << 20; sweep_len = 24'd5;
        step(); sweep_start = 1'b0;
        chk("sw_busy_start", 64'(busy0), 64'h1);
        chk("sw_f_start", 64'(fc0), 64'h0);
        nbusy = 1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (busy0) nbusy++;
            chk("sw_busy", 64'(busy0), (k < 5) ? 64'h1 : 64'h0);
            chk("sw_freq_cur", 64'(fc0), 64'((k <= 5 ? k : 5)) << 20);
        end
        chk("sw_busy_clocks", 64'(nbusy), 64'h5);

        // zero-length sweep does nothing
        sweep_start = 1'b1; sweep_len = 24'd0;
        step(); sweep_start = 1'b0;
        chk("sw0_busy", 64'(busy0), 64'h0);
        chk("sw0_freq_cur", 64'(fc0), 64'h50_0000);
        step();
        chk("sw0_busy_next", 64'(busy0), 64'h0);
        chk("sw0_freq_next", 64'(fc0), 64'h50_0000);

        // restart while busy: no increment on the restart edge
        sweep_start = 1'b1; sweep_step = 48'd1; sweep_len = 24'd4;
        step(); sweep_start = 1'b0;
        step(); step();
        chk("rs_before", 64'(fc0), 64'h50_0002);
        sweep_start = 1'b1; sweep_step = 48'd2; sweep_len = 24'd2;
        step(); sweep_start = 1'b0;
        chk("rs_noinc", 64'(fc0), 64'h50_0002);
        chk("rs_busy", 64'(busy0), 64'h1);
        step();
        chk("rs_inc1", 64'(fc0), 64'h50_0004);
        chk("rs_busy1", 64'(busy0), 64'h1);
        step();
        chk("rs_inc2", 64'(fc0), 64'h50_0006);
        chk("rs_done", 64'(busy0), 64'h0);
        step();
        chk("rs_hold", 64'(fc0), 64'h50_0006);

        // abort mid-sweep with a frequency write
        sweep_start = 1'b1; sweep_step = 48'd1 << 20; sweep_len = 24'd10;
        step(); sweep_start = 1'b0;
        step(); step();
        chk("ab_mid", 64'(fc0), 64'h70_0006);
        freq_wr = 1'b1; freq = 48'd7;
        step(); freq_wr = 1'b0;
        chk("ab_busy", 64'(busy0), 64'h0);
        chk("ab_freq_cur", 64'(fc0), 64'h7);
        step();
        chk("ab_freq_hold", 64'(fc0), 64'h7);

        // negative step wraps through zero
        sweep_start = 1'b1; sweep_step = 48'hFFFF_FFFF_FFFD; sweep_len = 24'd3;
        step(); sweep_start = 1'b0;
        step(); step(); step();
        chk("neg_freq_cur", 64'(fc0), 64'hFFFF_FFFF_FFFE);
        chk("neg_busy", 64'(busy0), 64'h0);

        // freq_wr beats sweep_start in the same cycle
        sweep_start = 1'b1; sweep_step = 48'd1; sweep_len = 24'd8;
        freq_wr = 1'b1; freq = 48'h1234;
        step(); sweep_start = 1'b0; freq_wr = 1'b0;
        chk("prio_freq_cur", 64'(fc0), 64'h1234);
        chk("prio_busy", 64'(busy0), 64'h0);
        step();
        chk("prio_freq_hold", 64'(fc0), 64'h1234);

        // reset in the middle of a sweep with a running accumulator
        freq_wr = 1'b1; freq = 48'd1 << 30;
        step(); freq_wr = 1'b0;
        step(); step();
        sweep_start = 1'b1; sweep_step = 48'd1; sweep_len = 24'd100;
        step(); sweep_start = 1'b0;
        step();
        chk("mr_busy_before", 64'(busy0), 64'h1);
        r = 1'b1;
        step(); r = 1'b0;
        chk("mr_freq_cur", 64'(fc0), 64'h0);
        chk("mr_busy", 64'(busy0), 64'h0);
        chk("mr_a", 64'(a0), 64'h0);
        step();
        chk("mr_a_next", 64'(a0), 64'h0);
        chk("mr_busy_next", 64'(busy0), 64'h0);
        chk("mr_freq_next", 64'(fc0), 64'h0);

        // dither statistics; offset is zero after the reset
        freq_wr = 1'b1; freq = F_DITH; sync = 1'b1;
        step(); freq_wr = 1'b0; sync = 1'b0;
        ideal = '0; sum = 0; bad0 = 0; bad1 = 0; dcnt = 0; aprev = '0;
        for (int k = 0; k < 65536; k++) begin
            step();
            e = {a1, 26'd0} - ideal;
            if (!((e < 48'h0000_0400_0000) || (e > 48'hFFFF_FC00_0000))) bad1++;
            if (a0 !== ideal[47:26]) bad0++;
            if (a1 !== ideal[47:26]) dcnt++;
            if (k > 0) begin
                dd  = a1 - aprev;
                sum = sum + longint'($signed(dd));
            end
            aprev = a1;
            ideal = ideal + F_DITH;
        end
        chk("plain_exact", 64'(bad0), 64'h0);
        chk("dith_bound", 64'(bad1), 64'h0);
        chk("dith_active", 64'((dcnt > 12000) && (dcnt < 20000)), 64'h1);
        err = sum * 64'sd67108864 - 64'sd65535 * longint'(F_DITH);
        tol = (64'sd65535 * 64'sd67108864) / 64'sd1000;
        chk("dith_mean", 64'((err <= tol) && (err >= -tol)), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nco_phase_acc.md
Name: nco_phase_acc

Overview:
- Numerically controlled phase generator that produces the angle word for the downstream 22-bit-angle sine/cosine stage (8-clock sincos_18).
- The output angle is unsigned and wraps modulo 2^NBA.
- Supports:
  - programmable frequency word
  - phase offset
  - synchronous phase clear
  - linear frequency sweep (chirp) engine
  - optional LFSR truncation dither

Parameters:
- NBF, 48: bits in frequency word and phase accumulator.
- NBA, 22: bits in output angle; must equal the sincos angle width.
- DITHER, 1: 1 = add 16-bit LFSR dither below the truncation point; 0 = plain truncation.
- NBC, 24: bits in sweep step counter.

Ports:
- c  in  1  clock; all logic on rising edge.
- r  in  1  reset, synchronous, active-high.
- freq_wr  in  1  load freq into the frequency register.
- freq  in  NBF  unsigned frequency word; phase advance per clock = freq / 2^NBF turns.
- poff_wr  in  1  load poff into the phase offset register.
- poff  in  NBA  unsigned phase offset in output-angle LSBs.
- sync  in  1  clear the phase accumulator.
- sweep_start  in  1  begin a sweep from the current frequency.
- sweep_step  in  NBF  two's-complement frequency increment per clock during a sweep.
- sweep_len  in  NBC  number of increments in a sweep.
- sweep_busy  out  1  high while a sweep is in progress.
- freq_cur  out  NBF  current frequency register value, for readback.
- a  out  NBA  angle to the sincos stage.

Behaviour:
- Reset (r=1 at an edge), all to zero:
  - f, poff_q, acc, cnt, sweep_busy, a
  - freq_cur = 0
  - LFSR loads seed 16'hACE1
  - r has priority over every other input.
- Frequency register f:
  - freq_wr=1: f <= freq.
  - freq_wr=1 also aborts any sweep: cnt <= 0, sweep_busy <= 0.
  - Else if sweep_busy: f <= f + sweep_step_q, modulo 2^NBF (wraps, no saturation).
  - freq_cur = f.
- Sweep control:
  - sweep_start=1 with freq_wr=0: sweep_step_q <= sweep_step; cnt <= sweep_len; sweep_busy <= (sweep_len != 0).
  - sweep_start while busy restarts the sweep with the new step and length; no increment is applied in that cycle.
  - While busy: cnt decrements by 1 each clock.
  - When cnt==1 the final increment is applied and sweep_busy falls on that same edge.
  - Result: exactly sweep_len increments, with f final = f0 + sweep_len*step.
  - sweep_len=0 is a no-op.
  - sweep_start and freq_wr in the same cycle: freq_wr wins; sweep_start is ignored.
- Phase offset: poff_wr=1 gives poff_q <= poff. The new value appears on a one clock later.
- Accumulator:
  - acc <= sync ? 0 : acc + f, using the f value before this edge's update.
  - sync and freq_wr in the same cycle: acc clears and f loads. The next edge adds the new f.
- Output:
  - a <= (trunc(acc + d) + poff_q) mod 2^NBA.
  - trunc takes bits [NBF-1 : NBF-NBA].
  - d = {lfsr, zeros}, aligned so the LFSR MSB sits at bit NBF-NBA-1; d = 0 when DITHER=0.
  - The dither add is NBF wide and wraps.
  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clock.
- Latency:
  - freq_wr at edge n: f valid after n; acc reflects it after n+1; a reflects it after n+2.
  - sync at edge n: a = poff_q + dither-term at edge n+1.
- No handshake backpressure: a is produced every clock; the consumer samples continuously.

Decomposition:
- Shared package nco_pkg holds:
  - default widths NBF, NBA, NBC
  - LFSR seed and tap mask constants
  - a function computing the dither alignment shift
- One natural sub-module: nco_lfsr (16-bit Galois LFSR with synchronous reset to seed and a 16-bit state output). Instantiated only when DITHER=1.

Test Plan:
- Reset and basic ramp:
  - Stimulus: DITHER=0; r for 2 clocks, then freq_wr with freq=1<<26.
  - Required response: a=0 until 2 clocks after the write, then a increments by exactly 1 per clock; wraps 4194303 -> 0.
- Phase offset:
  - Stimulus: freq=0; poff_wr with poff=22'h100000.
  - Required response: a=22'h100000 one clock after the write.
  - Stimulus: then sync.
  - Required response: a stays 22'h100000.
- Sweep:
  - Stimulus: f=0; sweep_start with step=1<<20, len=5.
  - Required response: sweep_busy high for exactly 5 clocks; freq_cur steps 1<<20 ... 5<<20 and holds 5<<20.
  - Stimulus: repeat with len=0.
  - Required response: busy never asserts.
- Abort and priority:
  - Stimulus: mid-sweep, freq_wr with freq=7.
  - Required response: busy drops on that edge; freq_cur=7.
  - Stimulus: sweep_start and freq_wr in the same cycle.
  - Required response: freq_cur=freq; busy=0.
- Mid-operation reset:
  - Stimulus: assert r during a sweep, with f=1<<30 and acc nonzero.
  - Required response: the next edge clears f, acc, sweep_busy, cnt and a; sweep_busy=0.
- Dither statistics:
  - Stimulus: DITHER=1; freq=(1<<25)+1 for 2^16 clocks.
  - Required response: mean of a differences equals freq/2^26 within 1e-3; a never jumps by more than 1 LSB over the ideal value.
